// File: rtl/sdiv_seq_if.sv
// Start/done handshake bundle for the sequential signed divider.
// SDIV_DBZ_EN adds the dbz flag to the bundle.
interface sdiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
`ifdef SDIV_DBZ_EN
    logic             dbz;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, done, dbz
    );
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, done, dbz
    );
`else
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, done
    );
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, done
    );
`endif
endinterface

// File: rtl/sdiv_seq.sv
// Sequential signed restoring divider, one quotient bit per clock, start/done handshake.
// Define SDIV_DBZ_EN for the divide-by-zero shortcut and the dbz flag.
module sdiv_seq #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    sdiv_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   r;
    logic [CW-1:0]    cnt;
    logic             sq;
    logic             sr;
`ifdef SDIV_DBZ_EN
    logic             zdiv;
    logic             hold;
`endif

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_nx;
    logic             ge;
    logic [WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0] dv_mag;

    always_comb begin
        r_sh   = (r << 1) | (WIDTH+1)'(a[WIDTH-1]);
        ge     = (r_sh >= {1'b0, b});
        r_nx   = ge ? (r_sh - {1'b0, b}) : r_sh;
        dd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        dv_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch below reads the pre-edge values of a, r and cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            a             <= '0;
            b             <= '0;
            r             <= '0;
            cnt           <= '0;
            sq            <= 1'b0;
            sr            <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.done      <= 1'b0;
`ifdef SDIV_DBZ_EN
            bus.dbz       <= 1'b0;
            zdiv          <= 1'b0;
            hold          <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    r   <= r_nx;
                    a   <= {a[WIDTH-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1))
                        state <= FIX;
                end
                FIX: begin
`ifdef SDIV_DBZ_EN
                    // Zero divisor waits one extra cycle here so done lands at E+2.
                    if (hold) begin
                        hold <= 1'b0;
                    end else if (zdiv) begin
                        bus.quotient  <= '1;
                        bus.remainder <= sr ? -a : a;
                        bus.dbz       <= 1'b1;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end else
`endif
                    begin
                        bus.quotient  <= sq ? -a : a;
                        bus.remainder <= sr ? -r[WIDTH-1:0] : r[WIDTH-1:0];
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end
                end
                default: begin
                    if (bus.start) begin
                        a             <= dd_mag;
                        b             <= dv_mag;
                        r             <= '0;
                        cnt           <= '0;
                        sq            <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        sr            <= bus.dividend[WIDTH-1];
                        bus.quotient  <= '0;
                        bus.remainder <= '0;
                        bus.done      <= 1'b0;
                        state         <= RUN;
`ifdef SDIV_DBZ_EN
                        bus.dbz       <= 1'b0;
                        zdiv          <= (bus.divisor == '0);
                        hold          <= (bus.divisor == '0);
                        if (bus.divisor == '0)
                            state <= FIX;
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdiv_seq.sv
// Scoreboard bench for sdiv_seq: directed corner cases, then 1000 random signed pairs.
// Expected results come from 64-bit signed arithmetic in the bench.
module tb_sdiv_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sdiv_seq_if #(.WIDTH(W)) bus();
    sdiv_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   seen  = 0;
    logic done_d = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int acc);
        exp_t   e;
        longint sa, sb, q, r;
        e.acc = acc;
        e.z   = 1'b0;
        e.lat = W + 1;
        if (b == 32'd0) begin
`ifdef SDIV_DBZ_EN
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.z   = 1'b1;
            e.lat = 2;
`else
            e.q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
            e.r = a;
`endif
        end else begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            q   = sa / sb;
            r   = sa % sb;
            e.q = q[31:0];
            e.r = r[31:0];
        end
        return e;
    endfunction

    // Monitor: scores each rising edge of done against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done && !done_d) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("quotient", bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
`ifdef SDIV_DBZ_EN
                check("dbz", {31'd0, bus.dbz}, {31'd0, e.z});
`endif
                seen++;
            end
        end
        done_d = bus.done;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit track);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (track) exp_q.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    task automatic wait_seen(input int s0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (seen != s0) return;
        end
        total++;
        bad++;
        $display("FAIL timeout: got no done within 60 cycles expected one result");
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b);
        int s0;
        s0 = seen;
        issue(a, b, 1'b1);
        wait_seen(s0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        int          s0;
        logic [31:0] a, b;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
`ifdef SDIV_DBZ_EN
        check("rst_dbz", {31'd0, bus.dbz}, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run(32'd100, 32'd7);
        run(-32'sd100, 32'd7);
        run(32'd100, -32'sd7);
        run(32'h8000_0000, 32'hFFFF_FFFF);
        run(32'h8000_0000, 32'd1);
        run(-32'sd5, 32'd0);

        // 50/3 with an ignored mid-RUN start carrying 9/2.
        s0 = seen;
        issue(32'd50, 32'd3, 1'b1);
`ifdef SDIV_DBZ_EN
        check("dbz_clear", {31'd0, bus.dbz}, 32'd0);
`endif
        repeat (9) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd2;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_seen(s0);

        // Back-to-back start from DONE.
        s0 = seen;
        issue(32'd9, 32'd2, 1'b1);
        check("done_drop", {31'd0, bus.done}, 32'd0);
        wait_seen(s0);

        // Reset mid-RUN aborts the operation.
        s0 = seen;
        issue(32'd1234, 32'd5, 1'b1);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        exp_q.delete();
        check("abort_quotient", bus.quotient, 32'd0);
        check("abort_remainder", bus.remainder, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_no_result", 32'(seen), 32'(s0));
        @(negedge clk);
        rst = 1'b0;
        run(32'd21, 32'd4);

        for (int i = 0; i < 1000; i++) begin
            a = ($urandom_range(0, 19) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(0, 15)) - 32'd8;
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'h8000_0000;
                4:       b = 32'($urandom_range(1, 1000));
                default: b = $urandom;
            endcase
            run(a, b);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
